// File: rtl/onehot_hold_pkg.sv
// Shared types for the one-hot hold decoder: code/line widths and the FSM state encoding.
package onehot_hold_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [OUT_W-1:0]  line_t;

endpackage

// File: rtl/onehot_hold_decoder_if.sv
// Code-in / line-out bundle of the hold decoder; master is the code producer, slave the decoder.
interface onehot_hold_decoder_if;

  logic                  en;
  logic                  code_valid;
  onehot_hold_pkg::code_t code;
  logic                  code_ready;
  onehot_hold_pkg::line_t Y;
  logic                  busy;
  logic                  done;

  modport master (
    output en, code_valid, code,
    input  code_ready, Y, busy, done
  );

  modport slave (
    input  en, code_valid, code,
    output code_ready, Y, busy, done
  );

endinterface

// File: rtl/dec3to8_onehot.sv
// Pure combinational 3-to-8 one-hot decoder; zero latency, no flow control.
module dec3to8_onehot
  import onehot_hold_pkg::*;
(
  input  code_t code_i,
  output line_t line_o
);

  always_comb begin
    line_o         = '0;
    line_o[code_i] = 1'b1;
  end

endmodule

// File: rtl/onehot_hold_decoder.sv
// Drives one-hot line for HOLD_CYCLES enabled cycles per accepted code; Y one cycle after accept.
// One active plus one pending code; code_ready drops while the pending slot is full or en is low.
module onehot_hold_decoder
  import onehot_hold_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  onehot_hold_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  code_t            act_q, act_d;
  code_t            pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  line_t            y_q, y_d;
  logic             done_q, done_d;
  logic             accept;
  line_t            act_line;

  // Decode the value the active register is about to hold so Y lands one cycle after accept.
  dec3to8_onehot u_dec (
    .code_i (act_d),
    .line_o (act_line)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      act_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      y_q         <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      y_q         <= y_d;
      done_q      <= done_d;
    end
  end

  always_comb begin : next_state
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_d       = act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    done_d      = 1'b0;
    accept      = bus.code_valid && bus.en && !pend_full_q;

    if (bus.en) begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            act_d   = bus.code;
            cnt_d   = CNT_RELOAD;
            state_d = DRIVE;
          end
        end
        DRIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (accept) begin
              pend_d      = bus.code;
              pend_full_d = 1'b1;
            end
          end else begin
            // Hold expiry: hand over to the next code on this same edge so Y has no gap.
            done_d = 1'b1;
            if (pend_full_q) begin
              act_d       = pend_q;
              cnt_d       = CNT_RELOAD;
              pend_full_d = 1'b0;
            end else if (accept) begin
              act_d = bus.code;
              cnt_d = CNT_RELOAD;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin : y_next
    y_d = (state_d == DRIVE) ? act_line : '0;
  end

  // en blanks the line without disturbing the held state, so drive resumes where it paused.
  always_comb begin : outputs
    bus.code_ready = bus.en && !pend_full_q;
    bus.busy       = (state_q == DRIVE) || pend_full_q;
    bus.Y          = bus.en ? y_q : '0;
    bus.done       = done_q;
  end

endmodule

// File: tb/tb_onehot_hold_decoder.sv
// Directed plus random bench for onehot_hold_decoder with a queue-based reference model and scoreboard.
module tb_onehot_hold_decoder;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;

  onehot_hold_decoder_if a_if ();
  onehot_hold_decoder_if b_if ();

  onehot_hold_decoder #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  onehot_hold_decoder #(.HOLD_CYCLES(1), .CNT_W(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  always #5 clk = ~clk;

  int         n_cmp;
  int         n_bad;
  logic [2:0] m_q[$];
  logic [7:0] sb[$];
  int         m_rem;
  logic       m_done;
  logic       m_acc;
  logic [7:0] run_code;
  int         run_len;
  logic [7:0] ys[13];
  logic [2:0] t2c[3];
  logic [2:0] t4c[4];
  int         idx;
  int         nd;
  int         nlow;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    sb.delete();
    m_rem   = 0;
    m_done  = 1'b0;
    m_acc   = 1'b0;
    run_len = 0;
    run_code = 8'h00;
  endtask

  // Transaction view: queue head is the code on the line, rem counts its enabled cycles left.
  task automatic model_step();
    logic acc;
    acc    = a_if.en && a_if.code_valid && (m_q.size() < 2);
    m_acc  = acc;
    m_done = 1'b0;
    if (a_if.en) begin
      if (m_q.size() > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          void'(m_q.pop_front());
          m_done = 1'b1;
          if (m_q.size() > 0) m_rem = HOLD;
        end
      end
      if (acc) begin
        m_q.push_back(a_if.code);
        sb.push_back(8'(1) << a_if.code);
        if (m_q.size() == 1) m_rem = HOLD;
      end
    end
  endtask

  task automatic check_a();
    logic [7:0] exp_y;
    logic [7:0] exp_line;
    exp_y = (a_if.en && m_q.size() > 0) ? (8'(1) << m_q[0]) : 8'h00;
    chk("y", a_if.Y, exp_y);
    chk("busy", a_if.busy, m_q.size() > 0);
    chk("ready", a_if.code_ready, a_if.en && (m_q.size() < 2));
    chk("done", a_if.done, m_done);
    chk("onehot_or_zero", $countones(a_if.Y) <= 1, 1'b1);
    if (a_if.code_valid === 1'b1) begin
      n_cmp++;
      assert (!$isunknown(a_if.code)) else begin
        n_bad++;
        $error("FAIL code_x observed=%b required=known", a_if.code);
      end
    end
    if (a_if.done === 1'b1) begin
      chk("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        exp_line = sb.pop_front();
        chk("txn_line", run_code, exp_line);
        chk("txn_len", run_len, HOLD);
      end
      run_len = 0;
    end
    if (a_if.Y !== 8'h00) begin
      if (run_len == 0) run_code = a_if.Y;
      else chk("txn_same", a_if.Y, run_code);
      run_len++;
    end
  endtask

  task automatic cyc(input logic en_v, input logic vld_v, input logic [2:0] code_v);
    a_if.en         = en_v;
    a_if.code_valid = vld_v;
    a_if.code       = code_v;
    @(negedge clk);
    check_a();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    a_if.en = 1'b0; a_if.code_valid = 1'b0; a_if.code = 3'd0;
    b_if.en = 1'b0; b_if.code_valid = 1'b0; b_if.code = 3'd0;
    model_reset();

    // Reset state
    #12;
    chk("rst_y", a_if.Y, 8'h00);
    chk("rst_busy", a_if.busy, 1'b0);
    chk("rst_done", a_if.done, 1'b0);
    chk("rst_ready_en0", a_if.code_ready, 1'b0);
    chk("rst_b_y", b_if.Y, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    a_if.en = 1'b1;
    b_if.en = 1'b1;
    #1;
    chk("idle_ready", a_if.code_ready, 1'b1);

    // Single code 5 held for four cycles
    cyc(1, 1, 3'd5);
    for (int i = 0; i < 4; i++) begin
      chk("t1_y", a_if.Y, 8'h20);
      chk("t1_done_lo", a_if.done, 1'b0);
      cyc(1, 0, 3'd0);
    end
    chk("t1_end_y", a_if.Y, 8'h00);
    chk("t1_done", a_if.done, 1'b1);
    chk("t1_busy", a_if.busy, 1'b0);
    cyc(1, 0, 3'd0);
    chk("t1_done_once", a_if.done, 1'b0);

    // Back-to-back 0,7,3 with valid held
    t2c = '{3'd0, 3'd7, 3'd3};
    idx = 0; nd = 0; nlow = 0;
    for (int i = 0; i < 13; i++) begin
      if (a_if.code_ready === 1'b0) nlow++;
      if (idx < 3) cyc(1, 1, t2c[idx]);
      else         cyc(1, 0, 3'd0);
      if (m_acc) idx++;
      ys[i] = a_if.Y;
      if (a_if.done === 1'b1) nd++;
    end
    for (int i = 0; i < 13; i++)
      chk("t2_y", ys[i], (i < 4) ? 8'h01 : (i < 8) ? 8'h80 : (i < 12) ? 8'h08 : 8'h00);
    chk("t2_done_count", nd, 3);
    chk("t2_ready_low_cycles", nlow, 6);

    // en gap of three cycles after two drive cycles of code 2
    cyc(1, 1, 3'd2);
    chk("t3_y0", a_if.Y, 8'h04);
    cyc(1, 0, 3'd0);
    chk("t3_y1", a_if.Y, 8'h04);
    cyc(1, 0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      a_if.en = 1'b0;
      #1;
      chk("t3_gap_y", a_if.Y, 8'h00);
      chk("t3_gap_ready", a_if.code_ready, 1'b0);
      chk("t3_gap_busy", a_if.busy, 1'b1);
      cyc(0, 0, 3'd0);
      chk("t3_gap_done", a_if.done, 1'b0);
    end
    a_if.en = 1'b1;
    #1;
    chk("t3_y2", a_if.Y, 8'h04);
    cyc(1, 0, 3'd0);
    chk("t3_y3", a_if.Y, 8'h04);
    chk("t3_done_lo", a_if.done, 1'b0);
    cyc(1, 0, 3'd0);
    chk("t3_end_y", a_if.Y, 8'h00);
    chk("t3_done", a_if.done, 1'b1);

    // HOLD_CYCLES=1 instance: one code per cycle
    t4c = '{3'd1, 3'd2, 3'd4, 3'd6};
    for (int i = 0; i < 4; i++) begin
      b_if.code_valid = 1'b1;
      b_if.code       = t4c[i];
      #1;
      chk("t4_ready", b_if.code_ready, 1'b1);
      cyc(1, 0, 3'd0);
      chk("t4_y", b_if.Y, 8'(1) << t4c[i]);
      chk("t4_done", b_if.done, i > 0);
    end
    b_if.code_valid = 1'b0;
    cyc(1, 0, 3'd0);
    chk("t4_end_y", b_if.Y, 8'h00);
    chk("t4_end_done", b_if.done, 1'b1);
    chk("t4_end_busy", b_if.busy, 1'b0);

    // Reset mid-hold of 6 with 1 pending
    cyc(1, 1, 3'd6);
    cyc(1, 1, 3'd1);
    cyc(1, 0, 3'd0);
    chk("t5_pre_y", a_if.Y, 8'h40);
    chk("t5_pre_ready", a_if.code_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_y", a_if.Y, 8'h00);
    chk("t5_rst_busy", a_if.busy, 1'b0);
    chk("t5_rst_done", a_if.done, 1'b0);
    model_reset();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 3'd0);
      chk("t5_post_y", a_if.Y, 8'h00);
    end
    chk("t5_ready_en1", a_if.code_ready, 1'b1);
    a_if.en = 1'b0;
    #1;
    chk("t5_ready_en0", a_if.code_ready, 1'b0);

    // Random valid/en stress
    for (int i = 0; i < 10000; i++)
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)));
    for (int i = 0; i < 20; i++)
      cyc(1, 0, 3'd0);
    chk("drain_sb", sb.size(), 0);
    chk("drain_busy", a_if.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
